// File: rtl/squash_ctrl_if.sv
// Branch-writeback, violation, commit and squashInfo signals seen by squash_ctrl.
// slave is the squash_ctrl side; master drives the inputs and observes the squash beat.
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 16
`endif

interface squash_ctrl_if #(
    parameter int unsigned BRU_NUM  = 2,
    parameter int unsigned ROB_SIZE = 64,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned FOLDPC_W = `MEMDEP_FOLDPC_WIDTH
);
    localparam int unsigned RIDX_W = $clog2(ROB_SIZE) + 1;

    logic [BRU_NUM-1:0]        i_bwb_vld;
    logic [BRU_NUM*RIDX_W-1:0] i_bwb_rob_idx;
    logic [BRU_NUM-1:0]        i_bwb_mispred;
    logic [BRU_NUM-1:0]        i_bwb_taken;
    logic [BRU_NUM*XLEN-1:0]   i_bwb_npc;
    logic                      i_viol_vld;
    logic [RIDX_W-1:0]         i_viol_rob_idx;
    logic [XLEN-1:0]           i_viol_ldpc_full;
    logic [FOLDPC_W-1:0]       i_viol_stpc;
    logic [FOLDPC_W-1:0]       i_viol_ldpc;
    logic                      i_commit_vld;
    logic [RIDX_W-1:0]         i_commit_rob_idx;
    logic                      o_squash_vld;
    logic                      o_squash_dueToBranch;
    logic                      o_squash_dueToViolation;
    logic                      o_squash_branch_taken;
    logic [XLEN-1:0]           o_squash_arch_pc;
    logic [FOLDPC_W-1:0]       o_squash_stpc;
    logic [FOLDPC_W-1:0]       o_squash_ldpc;
    logic                      o_pending;
    logic                      o_busy;

    modport slave (
        input  i_bwb_vld, i_bwb_rob_idx, i_bwb_mispred, i_bwb_taken, i_bwb_npc,
        input  i_viol_vld, i_viol_rob_idx, i_viol_ldpc_full, i_viol_stpc, i_viol_ldpc,
        input  i_commit_vld, i_commit_rob_idx,
        output o_squash_vld, o_squash_dueToBranch, o_squash_dueToViolation,
        output o_squash_branch_taken, o_squash_arch_pc, o_squash_stpc, o_squash_ldpc,
        output o_pending, o_busy
    );

    modport master (
        output i_bwb_vld, i_bwb_rob_idx, i_bwb_mispred, i_bwb_taken, i_bwb_npc,
        output i_viol_vld, i_viol_rob_idx, i_viol_ldpc_full, i_viol_stpc, i_viol_ldpc,
        output i_commit_vld, i_commit_rob_idx,
        input  o_squash_vld, o_squash_dueToBranch, o_squash_dueToViolation,
        input  o_squash_branch_taken, o_squash_arch_pc, o_squash_stpc, o_squash_ldpc,
        input  o_pending, o_busy
    );
endinterface

// File: rtl/squash_ctrl.sv
// Tracks the oldest pending mispredict/violation redirect and, when the ROB retires it,
// emits one squashInfo beat followed by a fixed-length busy (flush) window.
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 16
`endif

module squash_ctrl #(
    parameter int unsigned BRU_NUM      = 2,
    parameter int unsigned ROB_SIZE     = 64,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FOLDPC_W     = `MEMDEP_FOLDPC_WIDTH,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    squash_ctrl_if.slave bus
);
    localparam int unsigned RIDX_W = $clog2(ROB_SIZE) + 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_SQUASH, S_DRAIN} state_t;

    typedef struct packed {
        logic [RIDX_W-1:0]   idx;
        logic                br;
        logic                taken;
        logic [XLEN-1:0]     pc;
        logic [FOLDPC_W-1:0] stpc;
        logic [FOLDPC_W-1:0] ldpc;
    } rec_t;

    state_t              r_state;
    rec_t                r_rec;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sq_vld;
    logic                r_sq_br;
    logic                r_sq_viol;
    logic                r_sq_taken;
    logic [XLEN-1:0]     r_sq_pc;
    logic [FOLDPC_W-1:0] r_sq_stpc;
    logic [FOLDPC_W-1:0] r_sq_ldpc;
    logic                r_pending;
    logic                r_busy;

    rec_t w_best;
    logic w_best_vld;
    logic w_replace;
    logic w_commit_hit;

    // MSB of a rob index is the wrap flag; differing flags invert the idx ordering.
    function automatic logic older(input logic [RIDX_W-1:0] a, input logic [RIDX_W-1:0] b);
        if (a[RIDX_W-1] == b[RIDX_W-1])
            return a[RIDX_W-2:0] < b[RIDX_W-2:0];
        return a[RIDX_W-2:0] > b[RIDX_W-2:0];
    endfunction

    // Strictly-older replacement in scan order: lower port beats higher, branches beat the violation.
    always_comb begin
        w_best_vld = 1'b0;
        w_best     = '0;
        for (int unsigned p = 0; p < BRU_NUM; p++) begin
            if (bus.i_bwb_vld[p] && bus.i_bwb_mispred[p] &&
                (!w_best_vld || older(bus.i_bwb_rob_idx[p*RIDX_W +: RIDX_W], w_best.idx))) begin
                w_best_vld = 1'b1;
                w_best     = '{idx: bus.i_bwb_rob_idx[p*RIDX_W +: RIDX_W], br: 1'b1,
                               taken: bus.i_bwb_taken[p], pc: bus.i_bwb_npc[p*XLEN +: XLEN],
                               stpc: '0, ldpc: '0};
            end
        end
        if (bus.i_viol_vld && (!w_best_vld || older(bus.i_viol_rob_idx, w_best.idx))) begin
            w_best_vld = 1'b1;
            w_best     = '{idx: bus.i_viol_rob_idx, br: 1'b0, taken: 1'b0,
                           pc: bus.i_viol_ldpc_full, stpc: bus.i_viol_stpc, ldpc: bus.i_viol_ldpc};
        end
    end

    assign w_replace    = w_best_vld && older(w_best.idx, r_rec.idx);
    assign w_commit_hit = bus.i_commit_vld && (bus.i_commit_rob_idx == r_rec.idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rec      <= '0;
            r_cnt      <= '0;
            r_sq_vld   <= 1'b0;
            r_sq_br    <= 1'b0;
            r_sq_viol  <= 1'b0;
            r_sq_taken <= 1'b0;
            r_sq_pc    <= '0;
            r_sq_stpc  <= '0;
            r_sq_ldpc  <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_best_vld) begin
                        r_rec     <= w_best;
                        r_pending <= 1'b1;
                        r_state   <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_commit_hit) begin
                        r_sq_vld   <= 1'b1;
                        r_sq_br    <= r_rec.br;
                        r_sq_viol  <= ~r_rec.br;
                        r_sq_taken <= r_rec.taken;
                        r_sq_pc    <= r_rec.pc;
                        r_sq_stpc  <= r_rec.stpc;
                        r_sq_ldpc  <= r_rec.ldpc;
                        r_pending  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SQUASH;
                    end else if (w_replace) begin
                        r_rec <= w_best;
                    end
                end
                S_SQUASH: begin
                    r_sq_vld   <= 1'b0;
                    r_sq_br    <= 1'b0;
                    r_sq_viol  <= 1'b0;
                    r_sq_taken <= 1'b0;
                    r_sq_pc    <= '0;
                    r_sq_stpc  <= '0;
                    r_sq_ldpc  <= '0;
                    r_rec      <= '0;
                    r_cnt      <= CNT_W'(FLUSH_CYCLES);
                    r_state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_squash_vld            = r_sq_vld;
    assign bus.o_squash_dueToBranch    = r_sq_br;
    assign bus.o_squash_dueToViolation = r_sq_viol;
    assign bus.o_squash_branch_taken   = r_sq_taken;
    assign bus.o_squash_arch_pc        = r_sq_pc;
    assign bus.o_squash_stpc           = r_sq_stpc;
    assign bus.o_squash_ldpc           = r_sq_ldpc;
    assign bus.o_pending               = r_pending;
    assign bus.o_busy                  = r_busy;

endmodule

// File: doc/squash_ctrl.md
Name: squash_ctrl

Overview:
- Receiving end of the branch writeback interface and sending end of the squash interface.
- Collects mispredict writebacks from the BRUs and memory-ordering violation reports, and tracks the oldest pending redirect.
- When the ROB retires that instruction, emits one squashInfo beat to the frontend/FTQ and holds the core in a fixed-length flush window.
- Sits beside the ROB in the backend.

Parameters:
- BRU_NUM, 2, number of branch writeback ports
- ROB_SIZE, 64, ROB entries; RIDX_W = $clog2(ROB_SIZE)+1 (MSB is the wrap flag)
- XLEN, 64, pc width
- FOLDPC_W, `MEMDEP_FOLDPC_WIDTH, folded pc width
- FLUSH_CYCLES, 4, post-squash busy cycles (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_bwb_vld  in  BRU_NUM  branch writeback valid per port
- i_bwb_rob_idx  in  BRU_NUM*RIDX_W  rob index of branch
- i_bwb_mispred  in  BRU_NUM  branch was mispredicted
- i_bwb_taken  in  BRU_NUM  actual direction
- i_bwb_npc  in  BRU_NUM*XLEN  correct next pc
- i_viol_vld  in  1  load violation report
- i_viol_rob_idx  in  RIDX_W  rob index of violating load
- i_viol_ldpc_full  in  XLEN  load pc (refetch target)
- i_viol_stpc  in  FOLDPC_W  folded store pc
- i_viol_ldpc  in  FOLDPC_W  folded load pc
- i_commit_vld  in  1  ROB retiring its head this cycle
- i_commit_rob_idx  in  RIDX_W  rob index of retiring head
- o_squash_vld  out  1  squashInfo beat
- o_squash_dueToBranch  out  1
- o_squash_dueToViolation  out  1
- o_squash_branch_taken  out  1
- o_squash_arch_pc  out  XLEN  redirect pc
- o_squash_stpc  out  FOLDPC_W
- o_squash_ldpc  out  FOLDPC_W
- o_pending  out  1  a redirect is recorded
- o_busy  out  1  squash/flush in progress; ROB must not commit

Behaviour:
- Reset: all outputs 0; state IDLE; pending record cleared; counter 0.
- Age compare on rob idx {flag,idx}: a older than b iff (flags equal and a.idx<b.idx) or (flags differ and a.idx>b.idx).
- Candidates per cycle: each port with vld&mispred; the violation report. Non-mispredicted writebacks are ignored.
- States:
  - IDLE: any candidate -> record oldest, go to PEND.
  - PEND: a new candidate strictly older than the record replaces it. An equal index keeps the existing record. If i_commit_vld and i_commit_rob_idx == record idx -> go to SQUASH; all candidates that cycle are dropped.
  - SQUASH: o_squash_vld=1 for exactly one cycle, fields driven from the record. Branch: dueToBranch=1, arch_pc=npc, branch_taken=taken, stpc/ldpc=0. Violation: dueToViolation=1, arch_pc=load pc, branch_taken=0, stpc/ldpc from the report. Record cleared; counter loaded with FLUSH_CYCLES; go to DRAIN.
  - DRAIN: counter decrements each cycle; at 1 -> IDLE. Inputs ignored throughout.
- Output timing: o_squash_* are registered, so they assert the cycle after the commit match. o_busy=1 in SQUASH and DRAIN. o_pending=1 in PEND.
- Same-cycle selection:
  - Candidates from several ports are reduced oldest-first.
  - Exact index ties between ports: lower port wins.
  - Branch vs violation on an equal index: branch wins.
- Wrap-around: comparison correct across the flag flip. Equal idx with different flag is never simultaneously live.
- Commit of a non-matching index in PEND: no effect.
- Reset asserted mid-SQUASH/DRAIN: immediate return to IDLE with outputs 0.

Test Plan:
- Single branch: port0 mispred rob 0x05, npc 0x8000_0100, taken=1; commit 0x05 two cycles later -> next cycle o_squash_vld=1, dueToBranch=1, arch_pc=0x8000_0100, taken=1; o_busy high for 1+4 cycles.
- Oldest select: port0 rob 0x0A and port1 rob 0x03 in the same cycle, then a violation at rob 0x02 -> squash only on commit 0x02 with dueToViolation=1 and the load pc; commits of 0x03/0x0A earlier do nothing.
- Wrap: record rob {0,0x3E}, then candidate {1,0x01} -> record stays 0x3E; candidate {0,0x3D} replaces it.
- Drop during flush: candidates arriving in SQUASH/DRAIN -> o_pending stays 0 after DRAIN; no second squash.
- Tie: port0 and the violation both at rob 0x07 -> squash dueToBranch=1 on commit 0x07.
- Async reset asserted in DRAIN cycle 2 -> o_busy=0 and o_squash_vld=0 immediately; next candidate is accepted normally.
